// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array sequencer: one-hot state encoding,
// state bit positions and the drain-length helper.
package systolic_array_pkg;

    typedef enum logic [4:0] {
        SA_IDLE  = 5'b00001,
        SA_START = 5'b00010,
        SA_COMP  = 5'b00100,
        SA_HALT  = 5'b01000,
        SA_FINI  = 5'b10000
    } systolic_array_state_t;

    localparam int SA_IDLE_BIT  = 0;
    localparam int SA_START_BIT = 1;
    localparam int SA_COMP_BIT  = 2;
    localparam int SA_HALT_BIT  = 3;
    localparam int SA_FINI_BIT  = 4;

    // Cycles needed for the skewed wavefront to leave an n x n array.
    function automatic int SA_DRAIN_CYC(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/sa_down_counter.sv
// Loadable down-counter with synchronous clear; saturates at zero.
module sa_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for the weight-stationary systolic array: clears the PEs,
// feeds K operand vectors (stalling on empty buffers), drains, then pulses done.
module systolic_array_ctrl
    import systolic_array_pkg::*;
#(
    parameter int ARR_SIZE = 8,
    parameter int K_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [K_W-1:0] k_len_i,
    input  logic           abort_i,
    input  logic           feed_ready_i,
    output logic           feed_rd_o,
    output logic           feed_zero_o,
    output logic           pe_en_o,
    output logic           acc_clr_o,
    output logic [K_W-1:0] k_idx_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [4:0]     state_o
);

    localparam int DRAIN_W = $clog2(2 * ARR_SIZE - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(SA_DRAIN_CYC(ARR_SIZE));

    systolic_array_state_t state_q, state_d;
    logic [K_W-1:0]        k_len_q, k_len_d;
    logic [K_W-1:0]        k_idx_q, k_idx_d;
    logic                  drain_q, drain_d;

    logic                  drain_clr;
    logic                  drain_load;
    logic                  drain_dec;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic                  drain_zero;
    logic                  drain_last;

    sa_down_counter #(
        .WIDTH (DRAIN_W)
    ) u_drain_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (drain_clr),
        .load_i     (drain_load),
        .load_val_i (DRAIN_LOAD),
        .dec_i      (drain_dec),
        .cnt_o      (drain_cnt),
        .zero_o     (drain_zero)
    );

    // A zero count while draining cannot normally occur; treat it as the end too.
    assign drain_last = drain_zero || (drain_cnt == DRAIN_W'(1));

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        k_idx_d     = k_idx_q;
        drain_d     = drain_q;
        drain_clr   = 1'b0;
        drain_load  = 1'b0;
        drain_dec   = 1'b0;
        feed_rd_o   = 1'b0;
        feed_zero_o = 1'b0;
        pe_en_o     = 1'b0;
        acc_clr_o   = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        unique case (state_q)
            SA_IDLE: begin
                if (start_i) begin
                    state_d   = SA_START;
                    k_len_d   = k_len_i;
                    k_idx_d   = '0;
                    drain_d   = 1'b0;
                    drain_clr = 1'b1;
                end
            end
            SA_START: begin
                acc_clr_o = 1'b1;
                busy_o    = 1'b1;
                state_d   = (k_len_q == '0) ? SA_FINI : SA_COMP;
            end
            SA_COMP: begin
                busy_o = 1'b1;
                if (drain_q) begin
                    pe_en_o     = 1'b1;
                    feed_zero_o = 1'b1;
                    drain_dec   = 1'b1;
                    if (drain_last) begin
                        state_d = SA_FINI;
                        drain_d = 1'b0;
                    end
                end else begin
                    feed_rd_o = feed_ready_i;
                    pe_en_o   = feed_ready_i;
                    if (!feed_ready_i) begin
                        state_d = SA_HALT;
                    end else if (k_idx_q == k_len_q - K_W'(1)) begin
                        // Last vector: k_idx stays on it so it never passes K-1.
                        drain_d    = 1'b1;
                        drain_load = 1'b1;
                    end else begin
                        k_idx_d = k_idx_q + K_W'(1);
                    end
                end
            end
            SA_HALT: begin
                busy_o = 1'b1;
                if (feed_ready_i) begin
                    state_d = SA_COMP;
                end
            end
            SA_FINI: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = SA_IDLE;
                k_idx_d = '0;
            end
            default: begin
                state_d = SA_IDLE;
            end
        endcase

        if (abort_i && (state_q != SA_IDLE)) begin
            state_d    = SA_IDLE;
            k_idx_d    = '0;
            drain_d    = 1'b0;
            drain_clr  = 1'b1;
            drain_load = 1'b0;
            drain_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SA_IDLE;
            k_len_q <= '0;
            k_idx_q <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            k_idx_q <= k_idx_d;
            drain_q <= drain_d;
        end
    end

    assign k_idx_o = k_idx_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench: a cycle table for the nominal N=4 tile plus hand-written
// sequences for stall, K=0, abort, reset-in-HALT and the K_W=4 maximum tile.
module tb_systolic_array_ctrl;
    import systolic_array_pkg::*;

    logic clk;
    logic rst;

    logic        start4, abort4, ready4;
    logic [15:0] k4;
    logic        rd4, zero4, pe4, clr4, busy4, done4;
    logic [15:0] kidx4;
    logic [4:0]  st4;

    logic        start2, abort2, ready2;
    logic [3:0]  k2;
    logic        rd2, zero2, pe2, clr2, busy2, done2;
    logic [3:0]  kidx2;
    logic [4:0]  st2;

    int errors = 0;
    int checks = 0;

    systolic_array_ctrl #(.ARR_SIZE(4), .K_W(16)) dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .k_len_i(k4), .abort_i(abort4),
        .feed_ready_i(ready4), .feed_rd_o(rd4), .feed_zero_o(zero4), .pe_en_o(pe4),
        .acc_clr_o(clr4), .k_idx_o(kidx4), .busy_o(busy4), .done_o(done4), .state_o(st4)
    );

    systolic_array_ctrl #(.ARR_SIZE(2), .K_W(4)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .k_len_i(k2), .abort_i(abort2),
        .feed_ready_i(ready2), .feed_rd_o(rd2), .feed_zero_o(zero2), .pe_en_o(pe2),
        .acc_clr_o(clr2), .k_idx_o(kidx2), .busy_o(busy2), .done_o(done2), .state_o(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [15:0] k;
        logic        ready;
        logic [4:0]  st;
        logic        rd, zero, pe, clr, busy, done;
        logic [15:0] kidx;
    } vec_t;

    vec_t vecs[13];

    localparam logic [26:0] IDLE_OBS = {5'b00001, 6'b0, 16'h0};

    function automatic vec_t mk(logic s, logic [15:0] k, logic r, logic [4:0] st,
                                logic rd, logic z, logic pe, logic c, logic b,
                                logic d, logic [15:0] ki);
        vec_t v;
        v.start = s; v.k = k; v.ready = r; v.st = st;
        v.rd = rd; v.zero = z; v.pe = pe; v.clr = c; v.busy = b; v.done = d;
        v.kidx = ki;
        return v;
    endfunction

    function automatic logic [26:0] obs4();
        return {st4, rd4, zero4, pe4, clr4, busy4, done4, kidx4};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int reads, done_cyc, pe_cnt, kmax, done_cnt;

        rst = 1'b1;
        start4 = 0; abort4 = 0; ready4 = 0; k4 = '0;
        start2 = 0; abort2 = 0; ready2 = 0; k2 = '0;
        repeat (3) tick();
        #2;
        chk("reset_dut4", 64'(obs4()), 64'(IDLE_OBS));
        chk("reset_dut2", 64'({st2, rd2, zero2, pe2, clr2, busy2, done2, kidx2}),
            64'({5'b00001, 6'b0, 4'h0}));
        tick();
        rst = 1'b0;

        // Nominal tile N=4, K=3, buffers always ready.
        vecs[0]  = mk(1, 16'd3, 1, SA_IDLE,  0, 0, 0, 0, 0, 0, 16'd0);
        vecs[1]  = mk(0, 16'd0, 1, SA_START, 0, 0, 0, 1, 1, 0, 16'd0);
        vecs[2]  = mk(0, 16'd0, 1, SA_COMP,  1, 0, 1, 0, 1, 0, 16'd0);
        vecs[3]  = mk(0, 16'd0, 1, SA_COMP,  1, 0, 1, 0, 1, 0, 16'd1);
        vecs[4]  = mk(0, 16'd0, 1, SA_COMP,  1, 0, 1, 0, 1, 0, 16'd2);
        for (int i = 5; i <= 10; i++)
            vecs[i] = mk(0, 16'd0, 1, SA_COMP, 0, 1, 1, 0, 1, 0, 16'd2);
        vecs[11] = mk(0, 16'd0, 1, SA_FINI,  0, 0, 0, 0, 1, 1, 16'd2);
        vecs[12] = mk(0, 16'd0, 1, SA_IDLE,  0, 0, 0, 0, 0, 0, 16'd0);

        for (int i = 0; i < 13; i++) begin
            start4 = vecs[i].start; k4 = vecs[i].k; ready4 = vecs[i].ready; abort4 = 0;
            #2;
            $display("vec %0d: state=%b rd=%b zero=%b pe=%b kidx=%0d done=%b",
                     i, st4, rd4, zero4, pe4, kidx4, done4);
            chk($sformatf("nominal_c%0d", i), 64'(obs4()),
                64'({vecs[i].st, vecs[i].rd, vecs[i].zero, vecs[i].pe, vecs[i].clr,
                     vecs[i].busy, vecs[i].done, vecs[i].kidx}));
            tick();
        end
        start4 = 0;
        tick();

        // Single-cycle buffer underrun at cycle 3.
        reads = 0; done_cyc = -1;
        for (int c = 0; c <= 14; c++) begin
            start4 = (c == 0); k4 = 16'd3; ready4 = (c != 3);
            #2;
            if (rd4) reads++;
            if (done4 && done_cyc < 0) done_cyc = c;
            if (c == 3) chk("stall_no_read_c3", 64'({rd4, pe4}), 64'(2'b00));
            if (c == 4) chk("stall_halt_c4", 64'({st4, rd4, pe4}), 64'({SA_HALT, 2'b00}));
            if (c == 5) chk("stall_resume_c5", 64'({st4, rd4, kidx4}), 64'({SA_COMP, 1'b1, 16'd1}));
            if (c == 14) chk("stall_idle_c14", 64'(st4), 64'(SA_IDLE));
            tick();
        end
        $display("seq stall: reads=%0d done_cyc=%0d", reads, done_cyc);
        chk("stall_reads", 64'(reads), 64'(3));
        chk("stall_done_cyc", 64'(done_cyc), 64'(13));

        // Empty tile.
        reads = 0; done_cyc = -1; pe_cnt = 0;
        for (int c = 0; c <= 3; c++) begin
            start4 = (c == 0); k4 = 16'd0; ready4 = 1;
            #2;
            if (rd4) reads++;
            if (pe4) pe_cnt++;
            if (done4 && done_cyc < 0) done_cyc = c;
            if (c == 1) chk("k0_start_c1", 64'({st4, clr4}), 64'({SA_START, 1'b1}));
            if (c == 3) chk("k0_idle_c3", 64'(obs4()), 64'(IDLE_OBS));
            tick();
        end
        $display("seq k0: reads=%0d pe=%0d done_cyc=%0d", reads, pe_cnt, done_cyc);
        chk("k0_done_cyc", 64'(done_cyc), 64'(2));
        chk("k0_reads_pe", 64'({reads, pe_cnt}), 64'(0));

        // Abort mid-drain, then a K=1 tile.
        reads = 0; done_cyc = -1; done_cnt = 0;
        for (int c = 0; c <= 18; c++) begin
            start4 = (c == 0) || (c == 8);
            k4 = (c == 8) ? 16'd1 : 16'd3;
            abort4 = (c == 7); ready4 = 1;
            #2;
            if (done4) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c >= 8 && rd4) reads++;
            if (c == 7) chk("abort_in_drain_c7", 64'({st4, zero4}), 64'({SA_COMP, 1'b1}));
            if (c == 8) chk("abort_idle_c8", 64'(obs4()), 64'(IDLE_OBS));
            if (c == 10) chk("abort_k1_read_c10", 64'({rd4, kidx4}), 64'({1'b1, 16'd0}));
            if (c == 18) chk("abort_idle_c18", 64'(st4), 64'(SA_IDLE));
            tick();
        end
        abort4 = 0; start4 = 0;
        $display("seq abort: done_cyc=%0d done_cnt=%0d reads=%0d", done_cyc, done_cnt, reads);
        chk("abort_done_cyc", 64'(done_cyc), 64'(17));
        chk("abort_done_cnt", 64'(done_cnt), 64'(1));
        chk("abort_k1_reads", 64'(reads), 64'(1));

        // Reset while halted.
        for (int c = 0; c <= 6; c++) begin
            start4 = (c == 0); k4 = 16'd3; ready4 = !(c == 3 || c == 4);
            rst = (c == 5);
            #2;
            if (c == 5) chk("rst_in_halt_c5", 64'(st4), 64'(SA_HALT));
            if (c == 6) chk("rst_idle_c6", 64'(obs4()), 64'(IDLE_OBS));
            tick();
        end
        rst = 0;
        $display("seq rst_in_halt: state=%b", st4);

        // start_i held high while busy must not retrigger or change K.
        reads = 0; done_cyc = -1;
        for (int c = 0; c <= 12; c++) begin
            start4 = (c <= 11); k4 = (c == 0) ? 16'd3 : 16'd7; ready4 = 1;
            #2;
            if (rd4) reads++;
            if (done4 && done_cyc < 0) done_cyc = c;
            if (c == 12) chk("busy_start_idle_c12", 64'(st4), 64'(SA_IDLE));
            tick();
        end
        start4 = 0;
        $display("seq busy_start: reads=%0d done_cyc=%0d", reads, done_cyc);
        chk("busy_start_reads", 64'(reads), 64'(3));
        chk("busy_start_done_cyc", 64'(done_cyc), 64'(11));

        // Maximum tile on K_W=4, N=2.
        reads = 0; done_cyc = -1; kmax = 0;
        for (int c = 0; c <= 20; c++) begin
            start2 = (c == 0); k2 = 4'hF; ready2 = 1;
            #2;
            if (rd2) reads++;
            if (int'(kidx2) > kmax) kmax = int'(kidx2);
            if (done2 && done_cyc < 0) done_cyc = c;
            if (c == 16) chk("kmax_last_read_c16", 64'({rd2, kidx2}), 64'({1'b1, 4'd14}));
            if (c == 18) chk("kmax_drain_hold_c18", 64'({zero2, kidx2}), 64'({1'b1, 4'd14}));
            if (c == 20) chk("kmax_idle_c20", 64'(st2), 64'(SA_IDLE));
            tick();
        end
        start2 = 0;
        $display("seq kmax: reads=%0d kmax=%0d done_cyc=%0d", reads, kmax, done_cyc);
        chk("kmax_reads", 64'(reads), 64'(15));
        chk("kmax_kidx_max", 64'(kmax), 64'(14));
        chk("kmax_done_cyc", 64'(done_cyc), 64'(19));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
